// File: rtl/alu_share_seq.sv
// alu_share_seq: two-requester round-robin sequencer driving one shared 4-bit ALU.
// Latency: response valid 2 cycles after accept (narrow), 3 cycles (wide).
// Backpressure: response held in RESP until rsp_ready; no new accept until back in IDLE.
//
// Ports: clk/rst_n (async active-low); req0_*/req1_* valid/ready operation requests
// (op, wide, 8-bit a/b, cin); alu_* drive to / result from the external ALU;
// rsp_* registered response (id, 8-bit data, final carry) with valid/ready.
module alu_share_seq #(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_op,
  input  logic       req0_wide,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req0_cin,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_op,
  input  logic       req1_wide,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic       req1_cin,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_c,
  output logic [2:0] alu_s,
  input  logic [3:0] alu_o,
  input  logic       alu_cout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       rsp_cout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_ROT  = 3'd5;
  localparam logic [2:0] OP_ZERO = 3'd6;

  logic [1:0] r_state;
  logic       r_prio;
  logic       r_id;
  logic [2:0] r_op;
  logic       r_wide;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_cin;
  logic [7:0] r_res;
  logic       r_carry;

  logic w_idle;
  logic w_gnt1;
  logic w_chain;

  // Ready is masked while reset is held so no handshake can be seen during reset.
  assign w_idle     = rst_n & (r_state == S_IDLE);
  // Requester 1 wins when it is the only one asking or when it holds priority.
  assign w_gnt1     = req1_valid & (~req0_valid | r_prio);
  assign req1_ready = w_idle & w_gnt1;
  assign req0_ready = w_idle & req0_valid & ~w_gnt1;

  // Add and rotate carry the LO-pass carry-out into the HI pass.
  assign w_chain = (r_op == OP_ADD) | (r_op == OP_ROT);

  // ALU drive depends only on registered state, never on request inputs.
  always_comb begin
    alu_a = 4'h0;
    alu_b = 4'h0;
    alu_c = 1'b0;
    alu_s = OP_ZERO;
    case (r_state)
      S_LO: begin
        alu_a = r_a[3:0];
        alu_b = r_b[3:0];
        alu_c = r_cin;
        alu_s = r_op;
      end
      S_HI: begin
        alu_a = r_a[7:4];
        alu_b = r_b[7:4];
        alu_c = w_chain ? r_carry : r_cin;
        alu_s = r_op;
      end
      default: ;
    endcase
  end

  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_id;
  assign rsp_data  = r_res;
  assign rsp_cout  = r_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_prio  <= PRIO_INIT;
      r_id    <= 1'b0;
      r_op    <= 3'd0;
      r_wide  <= 1'b0;
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      r_cin   <= 1'b0;
      r_res   <= 8'h00;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req0_ready) begin
            r_id    <= 1'b0;
            r_op    <= req0_op;
            r_wide  <= req0_wide;
            r_a     <= req0_a;
            r_b     <= req0_b;
            r_cin   <= req0_cin;
            r_state <= S_LO;
          end else if (req1_ready) begin
            r_id    <= 1'b1;
            r_op    <= req1_op;
            r_wide  <= req1_wide;
            r_a     <= req1_a;
            r_b     <= req1_b;
            r_cin   <= req1_cin;
            r_state <= S_LO;
          end
        end
        S_LO: begin
          r_res[3:0] <= alu_o;
          r_carry    <= alu_cout;
          if (r_wide) begin
            r_state <= S_HI;
          end else begin
            r_res[7:4] <= 4'h0;
            r_state    <= S_RESP;
          end
        end
        S_HI: begin
          r_res[7:4] <= alu_o;
          r_carry    <= alu_cout;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            // The requester just served loses priority for the next contest.
            r_prio  <= ~r_id;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_seq.sv
// tb_alu_share_seq: self-checking bench for alu_share_seq with a behavioural ALU.
// Latency: n/a (bench).
// Backpressure: exercises rsp_ready stalls and pending requesters.
module tb_alu_share_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_wide, req0_cin;
  logic [2:0] req0_op;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_wide, req1_cin;
  logic [2:0] req1_op;
  logic [7:0] req1_a, req1_b;
  logic [3:0] alu_a, alu_b, alu_o;
  logic       alu_c, alu_cout;
  logic [2:0] alu_s;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [7:0] rsp_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_share_seq #(.PRIO_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_wide(req0_wide), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_wide(req1_wide), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_s(alu_s),
    .alu_o(alu_o), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout)
  );

  // 4-bit combinational ALU the sequencer is shared in front of.
  always_comb begin
    alu_o    = 4'h0;
    alu_cout = 1'b0;
    case (alu_s)
      3'd0: alu_o = ~alu_a;
      3'd1: {alu_cout, alu_o} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_c};
      3'd2: alu_o = alu_a & alu_b;
      3'd3: alu_o = alu_a | alu_b;
      3'd4: alu_o = alu_a ^ alu_b;
      3'd5: begin alu_o = {alu_a[2:0], alu_c}; alu_cout = alu_a[3]; end
      3'd7: begin alu_o = 4'hF; alu_cout = 1'b1; end
      default: ;
    endcase
  end

  // Whole-width reference: {cout, data} from the operation's arithmetic meaning.
  function automatic logic [8:0] ref_op(input logic [2:0] op, input logic wide,
                                        input logic [7:0] a, input logic [7:0] b,
                                        input logic cin);
    int w, m, ai, bi, r, co;
    w  = wide ? 8 : 4;
    m  = (1 << w) - 1;
    ai = int'(a) & m;
    bi = int'(b) & m;
    co = 0;
    case (op)
      3'd0: r = ~ai & m;
      3'd1: begin r = ai + bi + int'(cin); co = (r >> w) & 1; r = r & m; end
      3'd2: r = ai & bi;
      3'd3: r = ai | bi;
      3'd4: r = ai ^ bi;
      3'd5: begin r = ((ai << 1) | int'(cin)) & m; co = (ai >> (w - 1)) & 1; end
      3'd6: r = 0;
      default: begin r = m; co = 1; end
    endcase
    return {co[0], r[7:0]};
  endfunction

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic v, input logic [2:0] op,
                         input logic wide, input logic [7:0] a, input logic [7:0] b,
                         input logic cin);
    if (id) begin
      req1_valid = v; req1_op = op; req1_wide = wide; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = v; req0_op = op; req0_wide = wide; req0_a = a; req0_b = b; req0_cin = cin;
    end
  endtask

  task automatic chk_alu_idle(input string nm);
    chk8({nm, "_alu_a"}, {4'h0, alu_a}, 8'h00);
    chk8({nm, "_alu_b"}, {4'h0, alu_b}, 8'h00);
    chk1({nm, "_alu_c"}, alu_c, 1'b0);
    chk8({nm, "_alu_s"}, {5'h0, alu_s}, 8'h06);
  endtask

  // One full transaction: wait for grant, measure latency, check response,
  // optionally stall the response for 'stall' cycles.
  task automatic run_op(input logic id, input logic [2:0] op, input logic wide,
                        input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] ed, input logic ec, input int stall,
                        input string nm);
    bit got, seen;
    int lat;
    set_req(id, 1'b1, op, wide, a, b, cin);
    rsp_ready = (stall == 0);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) got = 1;
      step;
    end
    set_req(id, 1'b0, op, wide, a, b, cin);
    if (!got) begin
      chk1({nm, "_grant_timeout"}, 1'b0, 1'b1);
      return;
    end
    lat  = 1;
    seen = 0;
    while (!seen && lat < 8) begin
      #1;
      if (rsp_valid === 1'b1) seen = 1;
      else begin step; lat++; end
    end
    chki({nm, "_latency"}, lat, wide ? 3 : 2);
    chk1({nm, "_id"}, rsp_id, id);
    chk8({nm, "_data"}, rsp_data, ed);
    chk1({nm, "_cout"}, rsp_cout, ec);
    for (int s = 0; s < stall; s++) begin
      step;
      #1;
      chk1({nm, "_stall_valid"}, rsp_valid, 1'b1);
      chk8({nm, "_stall_data"}, rsp_data, ed);
    end
    rsp_ready = 1'b1;
    step;
  endtask

  typedef struct {
    logic [2:0] op;
    logic       wide;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] ed;
    logic       ec;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] r;
    logic [2:0] op;
    logic       wd, cn, id;
    logic [7:0] a, b;

    tbl[0]  = '{3'd1, 1'b0, 8'h04, 8'h05, 1'b0, 8'h09, 1'b0};
    tbl[1]  = '{3'd1, 1'b1, 8'hF8, 8'h0A, 1'b0, 8'h02, 1'b1};
    tbl[2]  = '{3'd1, 1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[3]  = '{3'd7, 1'b1, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1};
    tbl[4]  = '{3'd6, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{3'd0, 1'b0, 8'h35, 8'h00, 1'b0, 8'h0A, 1'b0};
    tbl[6]  = '{3'd2, 1'b1, 8'hA5, 8'h3C, 1'b0, 8'h24, 1'b0};
    tbl[7]  = '{3'd3, 1'b1, 8'hA5, 8'h3C, 1'b0, 8'hBD, 1'b0};
    tbl[8]  = '{3'd4, 1'b1, 8'hA5, 8'h3C, 1'b0, 8'h99, 1'b0};
    tbl[9]  = '{3'd5, 1'b1, 8'h81, 8'h00, 1'b1, 8'h03, 1'b1};
    tbl[10] = '{3'd5, 1'b0, 8'h09, 8'h00, 1'b0, 8'h02, 1'b1};
    tbl[11] = '{3'd1, 1'b0, 8'hAF, 8'h51, 1'b0, 8'h00, 1'b1};
    tbl[12] = '{3'd0, 1'b1, 8'h3C, 8'h00, 1'b0, 8'hC3, 1'b0};
    tbl[13] = '{3'd1, 1'b1, 8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    tbl[14] = '{3'd4, 1'b0, 8'h0F, 8'h0F, 1'b1, 8'h00, 1'b0};
    tbl[15] = '{3'd3, 1'b0, 8'hF0, 8'h0F, 1'b0, 8'h0F, 1'b0};

    // Reset state, with a valid held during reset to confirm ready stays low.
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 3'd1, 1'b0, 8'h00, 8'h00, 1'b0);
    set_req(1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0);
    #2;
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_id", rsp_id, 1'b0);
    chk8("rst_rsp_data", rsp_data, 8'h00);
    chk1("rst_rsp_cout", rsp_cout, 1'b0);
    chk1("rst_req0_ready", req0_ready, 1'b0);
    chk1("rst_req1_ready", req1_ready, 1'b0);
    chk_alu_idle("rst");
    req0_valid = 1'b0;
    step;
    step;
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // Table-driven vectors, alternating requesters.
    for (int i = 0; i < 16; i++) begin
      run_op(i[0], tbl[i].op, tbl[i].wide, tbl[i].a, tbl[i].b, tbl[i].cin,
             tbl[i].ed, tbl[i].ec, 0, $sformatf("vec%0d", i));
    end

    // Wide add: check ALU slice drive in LO and HI passes.
    set_req(1'b1, 1'b1, 3'd1, 1'b1, 8'hF8, 8'h0A, 1'b0);
    #1;
    chk1("wide_req1_ready", req1_ready, 1'b1);
    step;
    set_req(1'b1, 1'b0, 3'd1, 1'b1, 8'hF8, 8'h0A, 1'b0);
    #1;
    chk8("lo_alu_a", {4'h0, alu_a}, 8'h08);
    chk8("lo_alu_b", {4'h0, alu_b}, 8'h0A);
    chk1("lo_alu_c", alu_c, 1'b0);
    chk8("lo_alu_s", {5'h0, alu_s}, 8'h01);
    step;
    #1;
    chk8("hi_alu_a", {4'h0, alu_a}, 8'h0F);
    chk8("hi_alu_b", {4'h0, alu_b}, 8'h00);
    chk1("hi_alu_c", alu_c, 1'b1);
    step;
    #1;
    chk1("wide_rsp_valid", rsp_valid, 1'b1);
    chk8("wide_rsp_data", rsp_data, 8'h02);
    chk1("wide_rsp_cout", rsp_cout, 1'b1);
    step;

    // Simultaneous requests: priority back at requester 0 after last req1 service.
    set_req(1'b0, 1'b1, 3'd2, 1'b0, 8'h0C, 8'h0A, 1'b0);
    set_req(1'b1, 1'b1, 3'd2, 1'b0, 8'h03, 8'h07, 1'b0);
    #1;
    chk1("both_req0_ready", req0_ready, 1'b1);
    chk1("both_req1_ready", req1_ready, 1'b0);
    step;
    req0_valid = 1'b0;
    #1;
    chk1("both_lo_req1_ready", req1_ready, 1'b0);
    step;
    #1;
    chk1("both_rsp0_valid", rsp_valid, 1'b1);
    chk1("both_rsp0_id", rsp_id, 1'b0);
    chk8("both_rsp0_data", rsp_data, 8'h08);
    chk1("both_resp_req1_ready", req1_ready, 1'b0);
    step;
    #1;
    chk1("both_idle_req1_ready", req1_ready, 1'b1);
    step;
    req1_valid = 1'b0;
    step;
    #1;
    chk1("both_rsp1_valid", rsp_valid, 1'b1);
    chk1("both_rsp1_id", rsp_id, 1'b1);
    chk8("both_rsp1_data", rsp_data, 8'h03);
    step;

    // Response backpressure with a pending requester.
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 3'd4, 1'b0, 8'h06, 8'h03, 1'b0);
    step;
    req0_valid = 1'b0;
    set_req(1'b1, 1'b1, 3'd1, 1'b0, 8'h02, 8'h02, 1'b1);
    step;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk1("bp_valid", rsp_valid, 1'b1);
      chk1("bp_id", rsp_id, 1'b0);
      chk8("bp_data", rsp_data, 8'h05);
      chk1("bp_cout", rsp_cout, 1'b0);
      chk1("bp_req0_ready", req0_ready, 1'b0);
      chk1("bp_req1_ready", req1_ready, 1'b0);
      if (s < 4) step;
    end
    rsp_ready = 1'b1;
    step;
    #1;
    chk1("bp_done_valid", rsp_valid, 1'b0);
    run_op(1'b1, 3'd1, 1'b0, 8'h02, 8'h02, 1'b1, 8'h05, 1'b0, 0, "bp_pending");

    // Ones then zero.
    run_op(1'b0, 3'd7, 1'b1, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, 0, "ones_wide");
    run_op(1'b0, 3'd6, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, "zero_narrow");

    // Reset during the HI pass of a wide op; req1 pending across reset.
    set_req(1'b0, 1'b1, 3'd1, 1'b1, 8'h11, 8'h22, 1'b0);
    step;
    req0_valid = 1'b0;
    step;
    set_req(1'b1, 1'b1, 3'd3, 1'b0, 8'h05, 8'h0A, 1'b0);
    #1;
    chk8("pre_rst_hi_alu_a", {4'h0, alu_a}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk1("midrst_rsp_valid", rsp_valid, 1'b0);
    chk1("midrst_req1_ready", req1_ready, 1'b0);
    chk_alu_idle("midrst");
    step;
    rst_n = 1'b1;
    #1;
    chk1("postrst_rsp_valid", rsp_valid, 1'b0);
    chk1("postrst_req1_ready", req1_ready, 1'b1);
    chk_alu_idle("postrst");
    run_op(1'b1, 3'd3, 1'b0, 8'h05, 8'h0A, 1'b0, 8'h0F, 1'b0, 0, "postrst_op");

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      wd = 1'($urandom_range(0, 1));
      cn = 1'($urandom_range(0, 1));
      id = 1'($urandom_range(0, 1));
      a  = 8'($urandom);
      b  = 8'($urandom);
      r  = ref_op(op, wd, a, b, cn);
      run_op(id, op, wd, a, b, cn, r[7:0], r[8], $urandom_range(0, 2),
             $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_seq.md
Name: alu_share_seq

Overview:
- Sequencer and arbiter that shares the single 4-bit combinational ALU between two requesters (0 and 1).
- Each request is one ALU operation: narrow (4-bit, one ALU pass) or wide (8-bit, two passes, low nibble first).
- Round-robin arbitration, valid/ready request handshake, one registered response channel with backpressure.
- Sits between the traffic-control datapath clients and the ALU instance. The ALU is driven via alu_* ports.

Parameters:
PRIO_INIT, 0, requester that has priority after reset (0 or 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_op  input  3  ALU select: 0 not, 1 add, 2 and, 3 or, 4 xor, 5 rotate, 6 zero, 7 ones
req0_wide  input  1  1 = 8-bit operation, 0 = 4-bit (upper operand bits ignored)
req0_a  input  8  operand A
req0_b  input  8  operand B
req0_cin  input  1  carry/shift-in
req1_valid, req1_ready, req1_op, req1_wide, req1_a, req1_b, req1_cin: same as requester 0
alu_a  output  4  ALU operand A slice
alu_b  output  4  ALU operand B slice
alu_c  output  1  ALU carry/shift-in
alu_s  output  3  ALU function select
alu_o  input  4  ALU result
alu_cout  input  1  ALU carry-out
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes response
rsp_id  output  1  requester that issued the operation
rsp_data  output  8  result; bits 7:4 = 0 for narrow ops
rsp_cout  output  1  final ALU carry-out (HI pass if wide, LO pass otherwise)

Behaviour:
- FSM states: IDLE, LO, HI, RESP. Reset: state IDLE, priority pointer = PRIO_INIT, all registers 0.
  - Reset values at outputs: rsp_valid = 0, rsp_id = 0, rsp_data = 0x00, rsp_cout = 0, reqX_ready = 0.
  - ALU drive during reset: alu_a = 0, alu_b = 0, alu_c = 0, alu_s = 3'd6.
- IDLE:
  - Grant goes to the single valid requester. If both are valid, grant goes to the requester named by the priority pointer.
  - reqX_ready = 1 only for the granted requester, only in IDLE. It is combinational from valids, state and pointer.
  - On handshake, capture op, wide, a, b, cin and id. Next state is LO.
- LO:
  - Drive alu_a = a[3:0], alu_b = b[3:0], alu_c = cin, alu_s = op.
  - Capture res[3:0] <= alu_o and carry <= alu_cout.
  - If wide, next state is HI. Otherwise res[7:4] <= 0 and next state is RESP.
- HI:
  - Drive alu_a = a[7:4], alu_b = b[7:4], alu_s = op.
  - alu_c = captured carry for op 1 and op 5 (chaining). For all other ops, alu_c = captured cin.
  - Capture res[7:4] <= alu_o and carry <= alu_cout. Next state is RESP.
- RESP:
  - rsp_valid = 1. rsp_id, rsp_data and rsp_cout are registered and held stable until rsp_ready = 1.
  - On rsp_valid & rsp_ready: priority pointer <= ~id, next state is IDLE.
  - No new request is accepted in the same cycle (ready is only asserted in IDLE).
- ALU drive outside LO/HI: alu_a = 0, alu_b = 0, alu_c = 0, alu_s = 3'd6. alu_* outputs have no combinational path from reqX_* inputs.
- Latency, counting the accept cycle as cycle 0:
  - Narrow: rsp_valid asserted in cycle 2.
  - Wide: rsp_valid asserted in cycle 3.
  - Maximum throughput is one op per 3 cycles (narrow) or 4 cycles (wide) with rsp_ready held high.
- Requesters must hold their fields stable while valid & !ready. A valid with no grant remains pending; it is never dropped.
- Arithmetic: 8-bit add = two 4-bit adds with carry chained LO to HI. 0xFF + 0x01 gives rsp_data 0x00, rsp_cout 1. No other width extension.
- Reset asserted mid-operation (any state): the transaction is discarded, no response is issued, and the FSM returns to IDLE with the pointer at PRIO_INIT.
- Simultaneous events:
  - Both valid in IDLE: the pointer decides.
  - A requester that goes valid while another op is in flight waits; its ready stays 0 until IDLE.

Test Plan:
- Reset, then req0 narrow op1 a=0x04 b=0x05 cin=0, rsp_ready=1 -> req0_ready at cycle 0; rsp_valid at cycle 2 with rsp_id 0, rsp_data 0x09, rsp_cout 0.
- req1 wide op1 a=0xF8 b=0x0A cin=0 -> LO alu_a=8 alu_b=A alu_c=0; HI alu_a=F alu_b=0 alu_c=1; rsp_data 0x02, rsp_cout 1 at cycle 3.
- PRIO_INIT=0, req0 and req1 valid in the same cycle, both narrow op2 -> req0 served first; req1 accepted in the cycle after req0's response handshake; rsp_id sequence 0,1.
- rsp_ready held 0 for 4 cycles after rsp_valid -> rsp_valid and rsp_id/rsp_data/rsp_cout constant; req0_ready and req1_ready stay 0; the response completes on the first rsp_ready=1.
- req0 wide op7 a=0x00 b=0x00 -> rsp_data 0xFF, rsp_cout 1. Then narrow op6 -> rsp_data 0x00, rsp_cout 0.
- rst_n pulsed low during HI of a wide op -> no rsp_valid afterward; alu_s=6, alu_a=alu_b=alu_c=0; a pending req1 is granted in the first IDLE cycle after release.
